note_sequencer: RTL and testbench

Score-playback controller that sequences the 27-bit `note` input of `note_decoder_full`. It holds a small writable score of (key, duration) entries. On `start` it walks the score and drives each key onto `note` for the programmed number of ticks. An optional silent gap separates consecutive notes, and playback either stops or loops at end-of-score. It sits between the control/host logic and `note_decoder_full`, and is the only driver of that decoder's `note` input.

---
 rtl/note_sequencer_if.sv | 32 +++
 rtl/note_sequencer.sv | 151 +++++++++++++++
 tb/tb_note_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/note_sequencer_if.sv
// note_sequencer_if
// Bundles the score-write port, playback controls and playback status of
// note_sequencer.
//   master : host side. Drives wr_en/wr_addr/wr_key/wr_dur, start, stop, loop;
//            observes note, playing, done, pos.
//   slave  : sequencer side (the reverse directions).
// AW must equal clog2 of the sequencer's DEPTH.
interface note_sequencer_if #(
    parameter int AW = 6
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [6:0]    wr_key;
    logic [15:0]   wr_dur;
    logic          start;
    logic          stop;
    logic          loop;
    logic [26:0]   note;
    logic          playing;
    logic          done;
    logic [AW-1:0] pos;

    modport master (
        output wr_en, wr_addr, wr_key, wr_dur, start, stop, loop,
        input  note, playing, done, pos
    );

    modport slave (
        input  wr_en, wr_addr, wr_key, wr_dur, start, stop, loop,
        output note, playing, done, pos
    );
endinterface

// File: rtl/note_sequencer.sv
// note_sequencer
// Plays a writable score of (key, duration) entries onto the 27-bit note input
// of note_decoder_full. Each entry drives its key for dur ticks, followed by
// GAP_TICKS silent ticks; a zero duration marks end-of-score, where playback
// either stops (done pulse) or restarts at entry 0 when loop is high.
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    note_sequencer_if.slave: score write port (wr_en, wr_addr, wr_key,
//          wr_dur), controls (start, stop, loop), status (note, playing,
//          done, pos)
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | not playing, note silent
// S_FETCH | one cycle: read entry[pos], decide note / loop / end-of-score
// S_NOTE  | key on note, counting down the entry's ticks
// S_GAP   | silence between notes, counting down GAP_TICKS
module note_sequencer #(
    parameter int DEPTH     = 64,
    parameter int TICK_DIV  = 48000,
    parameter int GAP_TICKS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    note_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] LAST_POS = AW'(DEPTH - 1);
    localparam logic [15:0]   GAP_LOAD = 16'(GAP_TICKS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_NOTE  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    // {key[6:0], dur[15:0]}; deliberately not reset.
    logic [22:0] score [DEPTH];

    logic [1:0]    state_q, state_d;
    logic [26:0]   note_q, note_d;
    logic [AW-1:0] pos_q, pos_d;
    logic          done_q, done_d;
    logic          playing_q;
    logic [15:0]   tick_q, tick_d;
    logic [PW-1:0] pre_q, pre_d;

    logic [6:0]  f_key;
    logic [15:0] f_dur;
    logic        key_ok;

    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            score[bus.wr_addr] <= {bus.wr_key, bus.wr_dur};
        end
    end

    assign {f_key, f_dur} = score[pos_q];
    assign key_ok = (f_key >= 7'd1) && (f_key <= 7'd88);

    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        pos_d   = pos_q;
        done_d  = 1'b0;
        tick_d  = tick_q;
        pre_d   = pre_q;
        if (bus.stop) begin
            state_d = S_IDLE;
            note_d  = '0;
        end else if (bus.start) begin
            // Restart also covers start from IDLE; note is kept through FETCH.
            state_d = S_FETCH;
            pos_d   = '0;
            pre_d   = '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (f_dur != 16'd0) begin
                        state_d = S_NOTE;
                        note_d  = key_ok ? {20'd0, f_key} : 27'd0;
                        tick_d  = f_dur;
                        pre_d   = '0;
                    end else if ((pos_q != '0) && bus.loop) begin
                        pos_d  = '0;
                        note_d = '0;
                    end else begin
                        // An empty score never loops, so it cannot spin here.
                        state_d = S_IDLE;
                        note_d  = '0;
                        done_d  = 1'b1;
                    end
                end
                S_NOTE, S_GAP: begin
                    if (pre_q != PRE_MAX) begin
                        pre_d = pre_q + PW'(1);
                    end else begin
                        pre_d  = '0;
                        tick_d = tick_q - 16'd1;
                        if (tick_q == 16'd1) begin
                            if ((state_q == S_NOTE) && (GAP_TICKS != 0)) begin
                                state_d = S_GAP;
                                tick_d  = GAP_LOAD;
                                note_d  = '0;
                            end else if (pos_q != LAST_POS) begin
                                state_d = S_FETCH;
                                pos_d   = pos_q + AW'(1);
                            end else if (bus.loop) begin
                                // Running off the last entry is an implicit end marker.
                                state_d = S_FETCH;
                                pos_d   = '0;
                            end else begin
                                state_d = S_IDLE;
                                note_d  = '0;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            note_q    <= '0;
            pos_q     <= '0;
            done_q    <= 1'b0;
            playing_q <= 1'b0;
            tick_q    <= '0;
            pre_q     <= '0;
        end else begin
            state_q   <= state_d;
            note_q    <= note_d;
            pos_q     <= pos_d;
            done_q    <= done_d;
            playing_q <= (state_d != S_IDLE);
            tick_q    <= tick_d;
            pre_q     <= pre_d;
        end
    end

    assign bus.note    = note_q;
    assign bus.playing = playing_q;
    assign bus.done    = done_q;
    assign bus.pos     = pos_q;
endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int TD    = 4;
    localparam int GAP   = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    note_sequencer_if #(.AW(AW)) bus ();

    note_sequencer #(
        .DEPTH(DEPTH), .TICK_DIV(TD), .GAP_TICKS(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    logic [6:0]  sc_key [DEPTH];
    logic [15:0] sc_dur [DEPTH];

    typedef struct {
        logic [26:0]   note;
        logic          playing;
        logic          done;
        logic [AW-1:0] pos;
    } obs_t;
    obs_t exp_q[$];

    typedef struct {
        logic          start;
        logic          stop;
        logic          loop;
        int            count;
        logic [26:0]   note;
        logic          playing;
        logic          done;
        logic [AW-1:0] pos;
    } vec_t;
    vec_t tbl[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic [26:0] n, input logic p,
                           input logic d, input logic [AW-1:0] ps);
        chk({tag, ".note"}, 32'(bus.note), 32'(n));
        chk({tag, ".playing"}, 32'(bus.playing), 32'(p));
        chk({tag, ".done"}, 32'(bus.done), 32'(d));
        chk({tag, ".pos"}, 32'(bus.pos), 32'(ps));
    endtask

    task automatic write_entry(input int a, input int k, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(a);
        bus.wr_key  = 7'(k);
        bus.wr_dur  = 16'(d);
        step();
        bus.wr_en = 1'b0;
        sc_key[a] = 7'(k);
        sc_dur[a] = 16'(d);
    endtask

    // Walks the score by its rules and lists what each cycle after start should show.
    task automatic build_expect(input logic lp, input int cap);
        int p;
        logic [26:0] prev;
        logic [26:0] k;
        p = 0;
        prev = '0;
        exp_q.delete();
        while (exp_q.size() < cap) begin
            exp_q.push_back('{prev, 1'b1, 1'b0, AW'(p)});
            if (sc_dur[p] == 16'd0) begin
                if (p != 0 && lp) begin
                    p = 0;
                    prev = '0;
                    continue;
                end
                exp_q.push_back('{27'd0, 1'b0, 1'b1, AW'(p)});
                break;
            end
            k = (sc_key[p] >= 1 && sc_key[p] <= 88) ? 27'(sc_key[p]) : 27'd0;
            for (int i = 0; i < int'(sc_dur[p]) * TD; i++) exp_q.push_back('{k, 1'b1, 1'b0, AW'(p)});
            for (int i = 0; i < GAP * TD; i++) exp_q.push_back('{27'd0, 1'b1, 1'b0, AW'(p)});
            prev = (GAP != 0) ? 27'd0 : k;
            if (p == DEPTH - 1) begin
                if (lp) begin
                    p = 0;
                    continue;
                end
                exp_q.push_back('{27'd0, 1'b0, 1'b1, AW'(p)});
                break;
            end
            p++;
        end
    endtask

    task automatic run_model(input string tag, input logic lp, input int cap);
        int n;
        logic ended;
        build_expect(lp, cap);
        n = (exp_q.size() < cap) ? exp_q.size() : cap;
        ended = exp_q[n-1].done;
        bus.loop  = lp;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) step();
            chk_out(tag, exp_q[i].note, exp_q[i].playing, exp_q[i].done, exp_q[i].pos);
        end
        if (!ended) begin
            bus.stop = 1'b1;
            step();
            bus.stop = 1'b0;
        end else begin
            step();
        end
        chk({tag, ".end_playing"}, 32'(bus.playing), 32'd0);
        chk({tag, ".end_note"}, 32'(bus.note), 32'd0);
        chk({tag, ".end_done"}, 32'(bus.done), 32'd0);
        bus.loop = 1'b0;
    endtask

    task automatic load_basic();
        write_entry(0, 88, 2);
        write_entry(1, 1, 3);
        write_entry(2, 5, 0);
    endtask

    initial begin
        int term;
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_key = '0; bus.wr_dur = '0;
        bus.start = 0; bus.stop = 0; bus.loop = 0;
        step();
        step();
        rst_n = 1'b1;
        for (int a = 0; a < DEPTH; a++) write_entry(a, 0, 0);
        chk_out("reset", 27'd0, 1'b0, 1'b0, '0);

        // Basic playback, loop pass, loop dropped during second pass.
        load_basic();
        tbl.push_back('{1,0,0, 1,  0,1,0,0});
        tbl.push_back('{0,0,0, 8, 88,1,0,0});
        tbl.push_back('{0,0,0, 4,  0,1,0,0});
        tbl.push_back('{0,0,0, 1,  0,1,0,1});
        tbl.push_back('{0,0,0,12,  1,1,0,1});
        tbl.push_back('{0,0,0, 4,  0,1,0,1});
        tbl.push_back('{0,0,0, 1,  0,1,0,2});
        tbl.push_back('{0,0,0, 1,  0,0,1,2});
        tbl.push_back('{0,0,0, 3,  0,0,0,2});
        tbl.push_back('{1,0,1, 1,  0,1,0,0});
        tbl.push_back('{0,0,1, 8, 88,1,0,0});
        tbl.push_back('{0,0,1, 4,  0,1,0,0});
        tbl.push_back('{0,0,1, 1,  0,1,0,1});
        tbl.push_back('{0,0,1,12,  1,1,0,1});
        tbl.push_back('{0,0,1, 4,  0,1,0,1});
        tbl.push_back('{0,0,1, 1,  0,1,0,2});
        tbl.push_back('{0,0,1, 1,  0,1,0,0});
        tbl.push_back('{0,0,1, 8, 88,1,0,0});
        tbl.push_back('{0,0,0, 4,  0,1,0,0});
        tbl.push_back('{0,0,0, 1,  0,1,0,1});
        tbl.push_back('{0,0,0,12,  1,1,0,1});
        tbl.push_back('{0,0,0, 4,  0,1,0,1});
        tbl.push_back('{0,0,0, 1,  0,1,0,2});
        tbl.push_back('{0,0,0, 1,  0,0,1,2});
        tbl.push_back('{0,0,0, 2,  0,0,0,2});
        for (int r = 0; r < tbl.size(); r++) begin
            bus.start = tbl[r].start;
            bus.stop  = tbl[r].stop;
            bus.loop  = tbl[r].loop;
            for (int c = 0; c < tbl[r].count; c++) begin
                step();
                bus.start = 1'b0;
                bus.stop  = 1'b0;
                chk_out($sformatf("tbl%0d", r), tbl[r].note, tbl[r].playing, tbl[r].done, tbl[r].pos);
            end
        end
        bus.loop = 1'b0;

        // Reset for two cycles in the middle of a note.
        bus.start = 1'b1; step(); bus.start = 1'b0;
        step(); step();
        chk("pre_reset.note", 32'(bus.note), 32'd88);
        rst_n = 1'b0;
        step();
        chk_out("reset_mid1", 27'd0, 1'b0, 1'b0, '0);
        step();
        chk_out("reset_mid2", 27'd0, 1'b0, 1'b0, '0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out("post_reset", 27'd0, 1'b0, 1'b0, '0);
        end

        // Stop in the third cycle of note=88.
        bus.start = 1'b1; step(); bus.start = 1'b0;
        step(); step(); step();
        chk("stop_pre.note", 32'(bus.note), 32'd88);
        bus.stop = 1'b1; step(); bus.stop = 1'b0;
        chk_out("stop", 27'd0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stop_after.done", 32'(bus.done), 32'd0);
            chk("stop_after.playing", 32'(bus.playing), 32'd0);
        end

        // start and stop together.
        bus.start = 1'b1; bus.stop = 1'b1; step(); bus.start = 1'b0; bus.stop = 1'b0;
        chk("startstop.playing", 32'(bus.playing), 32'd0);
        step();
        chk("startstop.playing2", 32'(bus.playing), 32'd0);

        // Restart during the note of entry 1.
        bus.start = 1'b1; step(); bus.start = 1'b0;
        for (int i = 0; i < 14; i++) step();
        chk("restart_pre.note", 32'(bus.note), 32'd1);
        bus.start = 1'b1; step(); bus.start = 1'b0;
        chk("restart_fetch.pos", 32'(bus.pos), 32'd0);
        chk("restart_fetch.playing", 32'(bus.playing), 32'd1);
        step();
        chk("restart.note", 32'(bus.note), 32'd88);
        bus.stop = 1'b1; step(); bus.stop = 1'b0;

        // Rests and out-of-range keys.
        write_entry(0, 0, 2);
        write_entry(1, 95, 1);
        write_entry(2, 3, 0);
        run_model("rests", 1'b0, 400);

        // Empty score with loop.
        write_entry(0, 40, 0);
        bus.loop = 1'b1;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        chk("empty.fetch_playing", 32'(bus.playing), 32'd1);
        step();
        chk("empty.done", 32'(bus.done), 32'd1);
        chk("empty.playing", 32'(bus.playing), 32'd0);
        bus.loop = 1'b0;
        step();

        // Every entry non-zero.
        for (int a = 0; a < DEPTH; a++) write_entry(a, a + 10, 1);
        run_model("full_noloop", 1'b0, 400);
        run_model("full_loop", 1'b1, 100);

        // Random scores.
        for (int it = 0; it < 12; it++) begin
            term = $urandom_range(0, DEPTH);
            for (int a = 0; a < DEPTH; a++)
                write_entry(a, $urandom_range(0, 127), (a == term) ? 0 : $urandom_range(1, 3));
            run_model($sformatf("rand%0d", it), 1'($urandom_range(0, 1)), 250);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
